// File: rtl/rcpfa_pipe_adder.sv
// Pipelined W-bit adder with a per-beat approximate low region (forwarded-operand carry
// prediction) and a shadow exact sum that flags and counts approximation errors.
module rcpfa_pipe_adder #(
   parameter int unsigned W           = 16,
   parameter int unsigned STAGES      = 4,
   parameter int unsigned APPROX_BITS = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_cin,
   input  logic             in_approx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_sum,
   output logic             out_cout,
   output logic             out_err,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int unsigned SEG = W / STAGES;

   logic stall;

   // Approximate bits take their carry-in from the operand bit below (a_{i-1}); the rest ripple.
   function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                            input logic cin, input logic apx);
      logic [SEG-1:0] s;
      logic           c;
      s = '0;
      c = cin;
      for (int i = 0; i < int'(SEG); i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         if (apx && (i < int'(APPROX_BITS))) c = a[i];
         else                                 c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      return {c, s};
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int unsigned LO  = k * SEG;
      localparam int unsigned REM = W - (k + 1) * SEG;

      logic [W-LO-1:0]   a_in;
      logic [W-LO-1:0]   b_in;
      logic              c_in;
      logic              apx_in;
      logic              v_in;
      logic [W:0]        ex_in;
      logic [SEG:0]      seg;
      logic [LO+SEG-1:0] s_nxt;

      logic              v_q;
      logic              apx_q;
      logic              c_q;
      logic [W:0]        ex_q;
      logic [LO+SEG-1:0] s_q;

      if (k == 0) begin : g_src
         assign v_in   = in_valid & in_ready;
         assign a_in   = in_a;
         assign b_in   = in_b;
         assign c_in   = in_cin;
         assign apx_in = in_approx;
         assign ex_in  = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
         assign seg    = seg_add(a_in[SEG-1:0], b_in[SEG-1:0], c_in, in_approx);
         assign s_nxt  = seg[SEG-1:0];
      end else begin : g_src
         assign v_in   = g_stage[k-1].v_q;
         assign a_in   = g_stage[k-1].g_ops.a_q;
         assign b_in   = g_stage[k-1].g_ops.b_q;
         assign c_in   = g_stage[k-1].c_q;
         assign apx_in = g_stage[k-1].apx_q;
         assign ex_in  = g_stage[k-1].ex_q;
         assign seg    = seg_add(a_in[SEG-1:0], b_in[SEG-1:0], c_in, 1'b0);
         assign s_nxt  = {seg[SEG-1:0], g_stage[k-1].s_q};
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q   <= 1'b0;
            apx_q <= 1'b0;
            c_q   <= 1'b0;
            ex_q  <= '0;
            s_q   <= '0;
         end else if (!stall) begin
            v_q   <= v_in;
            apx_q <= apx_in;
            c_q   <= seg[SEG];
            ex_q  <= ex_in;
            s_q   <= s_nxt;
         end
      end

      // Only operand bits still to be added move on to the next segment.
      if (k < STAGES - 1) begin : g_ops
         logic [REM-1:0] a_q;
         logic [REM-1:0] b_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (!stall) begin
               a_q <= a_in[W-LO-1:SEG];
               b_q <= b_in[W-LO-1:SEG];
            end
         end
      end
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign out_sum   = g_stage[STAGES-1].s_q;
   assign out_cout  = g_stage[STAGES-1].c_q;
   assign out_err   = g_stage[STAGES-1].apx_q &
                      ({g_stage[STAGES-1].c_q, g_stage[STAGES-1].s_q} != g_stage[STAGES-1].ex_q);

   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall & ~rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (cnt_clr) begin
         err_cnt <= '0;
      end else if (out_valid && out_ready && out_err && (err_cnt != '1)) begin
         err_cnt <= err_cnt + CNT_W'(1);
      end
   end

endmodule
